pc_call_stack: RTL and testbench
================================

Name: pc_call_stack

Overview:
Parametrised program counter for the Hack CPU core, successor to the plain load/increment PC. It adds call/return support through an internal return-address stack (LIFO), a stall input, a configurable reset vector, and sticky overflow/underflow error flags. It sits between the instruction decoder (jump/call/ret strobes) and the instruction ROM address bus.

Parameters:
WIDTH, 16, address width in bits (PC and stack entries)
DEPTH, 8, number of return-address stack entries; must be >= 2
RESET_ADDR, 0, value loaded into o_Address on reset

Ports:
i_CLK  input  1  system clock, rising edge
i_RESET_n  input  1  asynchronous active-low reset
i_Stall  input  1  freeze all state this cycle
i_Call  input  1  push return address and jump to i_Address
i_Ret  input  1  pop the top of stack into PC
i_Load  input  1  jump to i_Address
i_Inc  input  1  PC <= PC + 1
i_ClearErr  input  1  clear the sticky error flags
i_Address  input  WIDTH  jump/call target
o_Address  output  WIDTH  current PC (registered)
o_Depth  output  $clog2(DEPTH+1)  number of valid stack entries
o_Full  output  1  o_Depth == DEPTH
o_Empty  output  1  o_Depth == 0
o_Overflow  output  1  sticky: a call was issued while full
o_Underflow  output  1  sticky: a ret was issued while empty

Behaviour:
- Reset is asynchronous and active-low, one clock (i_CLK).
- Reset values: o_Address = RESET_ADDR, o_Depth = 0, o_Empty = 1, o_Full = 0, o_Overflow = 0, o_Underflow = 0. Stack contents are don't-care.
- Reset asserted mid-operation discards any pending call or return immediately.
- Single-cycle latency: every operation takes effect on the next rising edge. o_Full and o_Empty are decoded combinationally from the registered depth.
- Operation priority, evaluated per edge: i_Stall > i_Call > i_Ret > i_Load > i_Inc > hold.
  - Only the highest-priority asserted operation executes.
  - Example: Call+Ret together performs Call only; Load+Inc performs Load.
- Stall: PC, stack, depth and flags all hold. i_ClearErr is also ignored while stalled.
- Call, not full:
  - stack[depth] <= o_Address + 1 (modulo 2^WIDTH)
  - depth <= depth + 1
  - o_Address <= i_Address
- Call, full:
  - o_Address <= i_Address (the jump still happens)
  - no push; depth unchanged
  - o_Overflow <= 1
- Ret, not empty: o_Address <= stack[depth-1]; depth <= depth - 1.
- Ret, empty: o_Address holds; depth stays 0; o_Underflow <= 1.
- Load: o_Address <= i_Address; stack untouched.
- Inc: o_Address <= o_Address + 1, wrapping 2^WIDTH-1 -> 0 with no flag.
- Return address wrap: a call from address 2^WIDTH-1 pushes 0.
- Error flags:
  - Sticky; cleared only by reset or by i_ClearErr on a non-stalled edge.
  - If a new error and i_ClearErr occur on the same edge, the new error wins and the flag reads 1.
- Stack storage is a plain register array indexed by depth; no read-during-write hazards are exposed.

Optional Feature:
PC_STACK_CIRCULAR_EN
- Defined: the stack is a circular buffer.
  - A call when full overwrites the oldest entry.
  - The write pointer advances, depth stays DEPTH, and o_Overflow is still set.
  - Subsequent returns yield the newest DEPTH addresses in LIFO order.
- Undefined: the call-when-full push is dropped, as described in Behaviour.

Test Plan:
- Reset/inc: RESET_ADDR=0x0010, release reset, 3 cycles of i_Inc -> o_Address 0x0010, 0x0011, 0x0012, 0x0013; o_Empty=1. Assert i_RESET_n=0 asynchronously mid-cycle -> o_Address=0x0010 immediately.
- Nested call/ret: at PC=0x0005, Call 0x0100, then Call 0x0200, then Ret, then Ret -> PC sequence 0x0100, 0x0200, 0x0101, 0x0006; o_Depth 1, 2, 1, 0.
- Overflow: DEPTH=8, nine calls to 0x0000..0x0008 starting at PC=0x0040 -> 9th jump taken, o_Depth=8, o_Full=1, o_Overflow=1. Then eight Rets -> eight return addresses popped in LIFO order, final PC=0x0041. i_ClearErr -> o_Overflow=0.
- Underflow/priority: Ret while empty at PC=0x0033 -> PC stays 0x0033, o_Underflow=1. Call+Ret+Load together with i_Address=0x0050 -> Call executes, o_Depth=1, pushed value 0x0034.
- Stall/wrap: PC=0xFFFF with i_Inc -> 0x0000. i_Stall with i_Call asserted -> PC, o_Depth and flags unchanged. Call from 0xFFFF -> pushes 0x0000.
- With PC_STACK_CIRCULAR_EN: DEPTH=4, calls from PCs A0..A4 -> four Rets return A4+1, A3+1, A2+1, A1+1; o_Overflow=1.

Source files
------------

// File: rtl/pc_call_stack_if.sv
// Purpose: decoder <-> program-counter bus (control strobes, jump target, PC and stack status).
// Latency: none; this file only groups wires.
// Backpressure: none; i_Stall is the only hold mechanism and is carried here as a plain strobe.
// Ports: master = instruction decoder (drives i_*), slave = pc_call_stack (drives o_*).
interface pc_call_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             i_Stall;
  logic             i_Call;
  logic             i_Ret;
  logic             i_Load;
  logic             i_Inc;
  logic             i_ClearErr;
  logic [WIDTH-1:0] i_Address;
  logic [WIDTH-1:0] o_Address;
  logic [DW-1:0]    o_Depth;
  logic             o_Full;
  logic             o_Empty;
  logic             o_Overflow;
  logic             o_Underflow;

  modport master (
    output i_Stall, i_Call, i_Ret, i_Load, i_Inc, i_ClearErr, i_Address,
    input  o_Address, o_Depth, o_Full, o_Empty, o_Overflow, o_Underflow
  );

  modport slave (
    input  i_Stall, i_Call, i_Ret, i_Load, i_Inc, i_ClearErr, i_Address,
    output o_Address, o_Depth, o_Full, o_Empty, o_Overflow, o_Underflow
  );
endinterface

// File: rtl/pc_call_stack.sv
// Purpose: Hack CPU program counter with call/return stack, stall, reset vector and sticky errors.
// Latency: every operation takes effect on the next rising i_CLK edge; full/empty decode from registered depth.
// Backpressure: i_Stall freezes PC, stack, depth and flags (i_ClearErr included).
// Ports: i_CLK, i_RESET_n (async active-low), bus (pc_call_stack_if.slave: strobes, target, PC, depth, status).
// Option: define PC_STACK_CIRCULAR_EN to make a call-when-full overwrite the oldest entry instead of dropping.
module pc_call_stack #(
  parameter int               WIDTH      = 16,
  parameter int               DEPTH      = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic            i_CLK,
  input  logic            i_RESET_n,
  pc_call_stack_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [WIDTH-1:0] addr_t;
  localparam addr_t ONE = addr_t'(1);

  addr_t          pc_q, pc_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic [PW-1:0]  ptr_q, ptr_d;       // next slot to write; top of stack is ptr_q-1 (mod DEPTH)
  addr_t          stack_q [DEPTH];
  addr_t          stack_d [DEPTH];
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic           full;
  logic           empty;
  logic [PW-1:0]  ptr_inc;
  logic [PW-1:0]  ptr_dec;
  addr_t          ret_addr;

  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == '0);
  // The pointer wraps explicitly so non-power-of-two depths stay in range.
  assign ptr_inc  = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  assign ptr_dec  = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - PW'(1);
  assign ret_addr = pc_q + ONE;       // wraps 2^WIDTH-1 -> 0 naturally

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ptr_d   = ptr_q;
    stack_d = stack_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!bus.i_Stall) begin
      // Clear first so an error raised on the same edge overrides it.
      if (bus.i_ClearErr) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (bus.i_Call) begin
        pc_d = bus.i_Address;
        if (!full) begin
          stack_d[ptr_q] = ret_addr;
          ptr_d          = ptr_inc;
          depth_d        = depth_q + DW'(1);
        end else begin
          ovf_d = 1'b1;
`ifdef PC_STACK_CIRCULAR_EN
          // When full, ptr_q points at the oldest entry; overwrite it and keep depth at DEPTH.
          stack_d[ptr_q] = ret_addr;
          ptr_d          = ptr_inc;
`endif
        end
      end else if (bus.i_Ret) begin
        if (!empty) begin
          pc_d    = stack_q[ptr_dec];
          ptr_d   = ptr_dec;
          depth_d = depth_q - DW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end else if (bus.i_Load) begin
        pc_d = bus.i_Address;
      end else if (bus.i_Inc) begin
        pc_d = pc_q + ONE;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign bus.o_Address   = pc_q;
  assign bus.o_Depth     = depth_q;
  assign bus.o_Full      = full;
  assign bus.o_Empty     = empty;
  assign bus.o_Overflow  = ovf_q;
  assign bus.o_Underflow = unf_q;
endmodule

// File: tb/tb_pc_call_stack.sv
// Purpose: self-checking bench for pc_call_stack (WIDTH=16, DEPTH=8, RESET_ADDR=0x0010).
// Latency: checks outputs #1 after each rising edge that follows the driven operation.
// Backpressure: exercises i_Stall against every other strobe.
module tb_pc_call_stack;
  localparam int          W  = 16;
  localparam int          D  = 8;
  localparam logic [15:0] RA = 16'h0010;

  localparam logic [5:0] OP_NONE  = 6'b000000;
  localparam logic [5:0] OP_STALL = 6'b100000;
  localparam logic [5:0] OP_CALL  = 6'b010000;
  localparam logic [5:0] OP_RET   = 6'b001000;
  localparam logic [5:0] OP_LOAD  = 6'b000100;
  localparam logic [5:0] OP_INC   = 6'b000010;
  localparam logic [5:0] OP_CLR   = 6'b000001;

  typedef struct {
    logic [5:0]  op;
    logic [15:0] addr;
    logic [15:0] e_pc;
    int          e_depth;
    bit          e_ovf;
    bit          e_unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_call_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pc_call_stack #(.WIDTH(W), .DEPTH(D), .RESET_ADDR(RA)) dut (
    .i_CLK     (clk),
    .i_RESET_n (rst_n),
    .bus       (bus)
  );

  int nvec = 0;
  int nmis = 0;

  // Reference model: PC value, a queue of return addresses (back = top), sticky flags.
  logic [15:0] m_pc;
  logic [15:0] m_q [$];
  bit          m_ovf;
  bit          m_unf;

  function automatic vec_t mk(logic [5:0] op, logic [15:0] addr, logic [15:0] e_pc,
                              int e_depth, bit e_ovf, bit e_unf);
    vec_t v;
    v.op = op; v.addr = addr; v.e_pc = e_pc; v.e_depth = e_depth; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic model_reset();
    m_pc = RA;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic [5:0] op, input logic [15:0] a);
    if (op[5]) return;
    if (op[0]) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (op[4]) begin
      if (m_q.size() < D) begin
        m_q.push_back(m_pc + 16'd1);
      end else begin
`ifdef PC_STACK_CIRCULAR_EN
        void'(m_q.pop_front());
        m_q.push_back(m_pc + 16'd1);
`endif
        m_ovf = 1'b1;
      end
      m_pc = a;
    end else if (op[3]) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else                m_unf = 1'b1;
    end else if (op[2]) begin
      m_pc = a;
    end else if (op[1]) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic check_exp(input string name, input logic [15:0] e_pc, input int e_depth,
                           input bit e_ovf, input bit e_unf);
    bit e_full, e_empty;
    e_full  = (e_depth == D);
    e_empty = (e_depth == 0);
    nvec++;
    if (bus.o_Address !== e_pc || int'(bus.o_Depth) != e_depth || bus.o_Full !== e_full ||
        bus.o_Empty !== e_empty || bus.o_Overflow !== e_ovf || bus.o_Underflow !== e_unf) begin
      nmis++;
      $display("FAIL %s: got pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
               name, bus.o_Address, bus.o_Depth, bus.o_Full, bus.o_Empty, bus.o_Overflow,
               bus.o_Underflow, e_pc, e_depth, e_full, e_empty, e_ovf, e_unf);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [15:0] a);
    {bus.i_Stall, bus.i_Call, bus.i_Ret, bus.i_Load, bus.i_Inc, bus.i_ClearErr} = op;
    bus.i_Address = a;
  endtask

  // Drive on the falling edge, let one rising edge pass, then compare with the model.
  task automatic step(input string name, input logic [5:0] op, input logic [15:0] a);
    @(negedge clk);
    drive(op, a);
    model_step(op, a);
    @(posedge clk);
    #1;
    check_exp(name, m_pc, m_q.size(), m_ovf, m_unf);
  endtask

  vec_t tbl [$];

  initial begin
    tbl.push_back(mk(OP_INC,                    16'h0000, 16'h0011, 0, 0, 0));
    tbl.push_back(mk(OP_INC,                    16'h0000, 16'h0012, 0, 0, 0));
    tbl.push_back(mk(OP_INC,                    16'h0000, 16'h0013, 0, 0, 0));
    tbl.push_back(mk(OP_LOAD,                   16'h0005, 16'h0005, 0, 0, 0));
    tbl.push_back(mk(OP_CALL,                   16'h0100, 16'h0100, 1, 0, 0));
    tbl.push_back(mk(OP_CALL,                   16'h0200, 16'h0200, 2, 0, 0));
    tbl.push_back(mk(OP_RET,                    16'h0000, 16'h0101, 1, 0, 0));
    tbl.push_back(mk(OP_RET,                    16'h0000, 16'h0006, 0, 0, 0));
    tbl.push_back(mk(OP_LOAD,                   16'h0033, 16'h0033, 0, 0, 0));
    tbl.push_back(mk(OP_RET,                    16'h0000, 16'h0033, 0, 0, 1));
    tbl.push_back(mk(OP_CALL | OP_RET | OP_LOAD, 16'h0050, 16'h0050, 1, 0, 1));
    tbl.push_back(mk(OP_RET,                    16'h0000, 16'h0034, 0, 0, 1));
    tbl.push_back(mk(OP_CLR,                    16'h0000, 16'h0034, 0, 0, 0));
    tbl.push_back(mk(OP_LOAD,                   16'hFFFF, 16'hFFFF, 0, 0, 0));
    tbl.push_back(mk(OP_INC,                    16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(OP_LOAD,                   16'hFFFF, 16'hFFFF, 0, 0, 0));
    tbl.push_back(mk(OP_STALL | OP_CALL,        16'h1234, 16'hFFFF, 0, 0, 0));
    tbl.push_back(mk(OP_CALL,                   16'h1234, 16'h1234, 1, 0, 0));
    tbl.push_back(mk(OP_RET,                    16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(OP_LOAD | OP_INC,          16'h0777, 16'h0777, 0, 0, 0));
    tbl.push_back(mk(OP_RET | OP_CLR,           16'h0000, 16'h0777, 0, 0, 1));
    tbl.push_back(mk(OP_STALL | OP_CLR,         16'h0000, 16'h0777, 0, 0, 1));
    tbl.push_back(mk(OP_CLR,                    16'h0000, 16'h0777, 0, 0, 0));

    // Reset state.
    drive(OP_NONE, 16'h0000);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_exp("reset", RA, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle with a call pending: PC returns to the vector at once.
    step("pre_rst_inc0", OP_INC, 16'h0000);
    step("pre_rst_inc1", OP_INC, 16'h0000);
    @(negedge clk);
    drive(OP_CALL, 16'h0ABC);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_exp("async_rst_mid", RA, 0, 0, 0);
    @(posedge clk);
    #1;
    check_exp("rst_discards_call", RA, 0, 0, 0);
    @(negedge clk);
    drive(OP_NONE, 16'h0000);
    rst_n = 1'b1;

    // Table-driven directed vectors (start from the reset vector).
    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("tbl%0d_model", i), tbl[i].op, tbl[i].addr);
      check_exp($sformatf("tbl%0d", i), tbl[i].e_pc, tbl[i].e_depth, tbl[i].e_ovf, tbl[i].e_unf);
    end

    // Overflow: nine calls from 0x0040 to 0x0000..0x0008, then eight returns.
    step("ovf_load", OP_LOAD, 16'h0040);
    for (int k = 0; k < 9; k++) begin
      step($sformatf("ovf_call%0d", k), OP_CALL, 16'(k));
    end
    check_exp("ovf_full", 16'h0008, D, 1, 0);
    for (int k = 0; k < 8; k++) begin
      step($sformatf("ovf_ret%0d", k), OP_RET, 16'h0000);
    end
`ifdef PC_STACK_CIRCULAR_EN
    check_exp("ovf_final", 16'h0001, 0, 1, 0);
`else
    check_exp("ovf_final", 16'h0041, 0, 1, 0);
`endif
    step("ovf_clear", OP_CLR, 16'h0000);
    check_exp("ovf_cleared", m_pc, 0, 0, 0);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] op;
      op[5] = ($urandom_range(0, 99) < 10);
      op[4] = ($urandom_range(0, 99) < 30);
      op[3] = ($urandom_range(0, 99) < 30);
      op[2] = ($urandom_range(0, 99) < 15);
      op[1] = ($urandom_range(0, 99) < 40);
      op[0] = ($urandom_range(0, 99) < 8);
      step("rand", op, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
